// File: rtl/floppy_period_bank.sv
// ============================================================================
// floppy_period_bank: receives note periods over a 4-phase handshake and
// latches them into NUM_DRIVES clamped period registers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module floppy_period_bank #(
    parameter int NUM_DRIVES  = 8,
    parameter int PERIOD_W    = 16,
    parameter int MIN_PERIOD  = 16,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 8
) (
    input  logic                           clock_98k,
    input  logic                           reset,
    input  logic                           clock_valid,
    input  logic [NUM_DRIVES*PERIOD_W-1:0] period_in,
    input  logic [NUM_DRIVES-1:0]          update_mask,
    input  logic                           floppy_command,
    output logic                           floppy_response,
    output logic [NUM_DRIVES*PERIOD_W-1:0] period_out,
    output logic                           busy,
    output logic                           timeout_err,
    output logic [CNT_W-1:0]               update_count,
    output logic [2:0]                     state_out
);

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_WAIT    = 3'd1,
        S_RECEIVE = 3'd2,
        S_ACK     = 3'd3,
        S_HOLD    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    localparam int                 TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]      HOLD_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]      HOLD_SAT  = TW'(TIMEOUT_CYC);
    localparam logic [PERIOD_W-1:0] MIN_P    = PERIOD_W'(MIN_PERIOD);

    state_t        state;
    logic [TW-1:0] hold_cnt;

    // Zero means silence and passes through; other short periods are raised to the floor.
    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] v);
        if (v == '0)
            return '0;
        else if (v < MIN_P)
            return MIN_P;
        else
            return v;
    endfunction

    always_ff @(posedge clock_98k) begin
        if (clock_valid) begin
            if (reset) begin
                state           <= S_RESET;
                period_out      <= '0;
                floppy_response <= 1'b0;
                busy            <= 1'b1;
                timeout_err     <= 1'b0;
                update_count    <= '0;
                hold_cnt        <= '0;
            end else begin
                case (state)
                    S_RESET: begin
                        state           <= S_WAIT;
                        busy            <= 1'b0;
                        floppy_response <= 1'b0;
                    end
                    S_WAIT: begin
                        if (floppy_command) begin
                            state <= S_RECEIVE;
                            busy  <= 1'b1;
                        end
                    end
                    S_RECEIVE: begin
                        for (int k = 0; k < NUM_DRIVES; k++) begin
                            if (update_mask[k])
                                period_out[k*PERIOD_W +: PERIOD_W] <=
                                    clamp_period(period_in[k*PERIOD_W +: PERIOD_W]);
                        end
                        update_count    <= update_count + 1'b1;
                        state           <= S_ACK;
                        floppy_response <= 1'b1;
                    end
                    S_ACK: begin
                        state    <= S_HOLD;
                        hold_cnt <= '0;
                    end
                    S_HOLD: begin
                        if (!floppy_command) begin
                            state           <= S_WAIT;
                            floppy_response <= 1'b0;
                            busy            <= 1'b0;
                        end else if (hold_cnt >= HOLD_LAST) begin
                            state           <= S_ERR;
                            floppy_response <= 1'b0;
                            timeout_err     <= 1'b1;
                        end
                        if (hold_cnt != HOLD_SAT)
                            hold_cnt <= hold_cnt + 1'b1;
                    end
                    S_ERR: begin
                        if (!floppy_command) begin
                            state <= S_WAIT;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state           <= S_RESET;
                        floppy_response <= 1'b0;
                        busy            <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign state_out = state;

endmodule

`default_nettype wire

// File: tb/tb_floppy_period_bank.sv
// ============================================================================
// tb_floppy_period_bank: randomized handshake stimulus checked against a
// transaction-level model of the period bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_floppy_period_bank;

    localparam int N   = 8;
    localparam int W   = 16;
    localparam int MINP = 16;
    localparam int TO  = 20;
    localparam int CW  = 4;

    logic             clock_98k = 1'b0;
    logic             reset = 1'b1;
    logic             clock_valid = 1'b1;
    logic [N*W-1:0]   period_in = '0;
    logic [N-1:0]     update_mask = '0;
    logic             floppy_command = 1'b0;
    logic             floppy_response;
    logic [N*W-1:0]   period_out;
    logic             busy;
    logic             timeout_err;
    logic [CW-1:0]    update_count;
    logic [2:0]       state_out;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] exp_p [N];
    int           exp_cnt = 0;
    logic         exp_err = 1'b0;

    floppy_period_bank #(
        .NUM_DRIVES(N), .PERIOD_W(W), .MIN_PERIOD(MINP), .TIMEOUT_CYC(TO), .CNT_W(CW)
    ) dut (
        .clock_98k(clock_98k), .reset(reset), .clock_valid(clock_valid),
        .period_in(period_in), .update_mask(update_mask),
        .floppy_command(floppy_command), .floppy_response(floppy_response),
        .period_out(period_out), .busy(busy), .timeout_err(timeout_err),
        .update_count(update_count), .state_out(state_out)
    );

    always #5 clock_98k = ~clock_98k;

    task automatic tick();
        @(posedge clock_98k);
        #1;
    endtask

    function automatic logic [N*W-1:0] exp_vec();
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = exp_p[k];
        return r;
    endfunction

    // Spec rule: zero is silence, short nonzero periods rise to MINP.
    function automatic logic [W-1:0] ref_clamp(input logic [W-1:0] v);
        if (v == 0) return '0;
        if (int'(v) < MINP) return W'(MINP);
        return v;
    endfunction

    function automatic logic [W-1:0] rand_period();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return W'($urandom_range(1, MINP - 1));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) exp_p[k] = '0;
        exp_cnt = 0;
        exp_err = 1'b0;
    endtask

    task automatic model_receive(input logic [N*W-1:0] pin, input logic [N-1:0] m);
        for (int k = 0; k < N; k++)
            if (m[k]) exp_p[k] = ref_clamp(pin[k*W +: W]);
        exp_cnt = (exp_cnt + 1) % (1 << CW);
    endtask

    // One full 4-phase exchange starting from WAIT.
    task automatic transfer(input string name, input logic [N*W-1:0] pin,
                            input logic [N-1:0] m, input bit drop_in_ack);
        period_in      = pin;
        update_mask    = m;
        floppy_command = 1'b1;
        tick();
        vectors++;
        if ({state_out, floppy_response, busy} !== {3'd2, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL %s/receive: state/resp/busy=%0h/%0b/%0b want 2/0/1", name, state_out, floppy_response, busy);
        end
        model_receive(pin, m);
        tick();
        vectors++;
        if ({state_out, floppy_response, period_out, update_count} !==
            {3'd3, 1'b1, exp_vec(), CW'(exp_cnt)}) begin
            miscompares++;
            $display("FAIL %s/ack: state=%0d resp=%0b periods=%h cnt=%0d want 3 1 %h %0d",
                     name, state_out, floppy_response, period_out, update_count, exp_vec(), exp_cnt);
        end
        period_in = {N{W'($urandom)}};
        if (drop_in_ack) floppy_command = 1'b0;
        tick();
        vectors++;
        if ({state_out, floppy_response} !== {3'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL %s/hold: state/resp=%0d/%0b want 4/1", name, state_out, floppy_response);
        end
        floppy_command = 1'b0;
        tick();
        vectors++;
        if ({state_out, floppy_response, busy, period_out} !== {3'd1, 1'b0, 1'b0, exp_vec()}) begin
            miscompares++;
            $display("FAIL %s/release: state=%0d resp=%0b busy=%0b periods=%h want 1 0 0 %h",
                     name, state_out, floppy_response, busy, period_out, exp_vec());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        model_reset();
        vectors++;
        if ({state_out, floppy_response, busy, timeout_err, update_count, period_out} !==
            {3'd0, 1'b0, 1'b1, 1'b0, CW'(0), exp_vec()}) begin
            miscompares++;
            $display("FAIL reset: state=%0d resp=%0b busy=%0b err=%0b cnt=%0d periods=%h want 0 0 1 0 0 0",
                     state_out, floppy_response, busy, timeout_err, update_count, period_out);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if ({state_out, busy} !== {3'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_to_wait: state/busy=%0d/%0b want 1/0", state_out, busy);
        end
    endtask

    task automatic test_full_update();
        transfer("full_update", {N{16'h01BD}}, 8'hFF, 1'b0);
    endtask

    task automatic test_mask();
        transfer("mask", {N{16'h0100}}, 8'h05, 1'b0);
    endtask

    task automatic test_clamp();
        logic [N*W-1:0] pin;
        pin = {N{16'h0400}};
        pin[3*W +: W] = 16'h0005;
        pin[4*W +: W] = 16'h0000;
        pin[5*W +: W] = W'(MINP);
        pin[6*W +: W] = W'(MINP - 1);
        transfer("clamp", pin, 8'hFF, 1'b0);
    endtask

    task automatic test_random();
        logic [N*W-1:0] pin;
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < N; k++) pin[k*W +: W] = rand_period();
            transfer("random", pin, N'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_reset_in_hold();
        logic [N*W-1:0] pin;
        transfer("pre_reset", {N{16'h0333}}, 8'hFF, 1'b0);
        period_in      = {N{16'h0222}};
        update_mask    = 8'hFF;
        floppy_command = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        model_reset();
        vectors++;
        if ({state_out, floppy_response, period_out, update_count} !== {3'd0, 1'b0, exp_vec(), CW'(0)}) begin
            miscompares++;
            $display("FAIL reset_hold: state=%0d resp=%0b periods=%h cnt=%0d want 0 0 0 0",
                     state_out, floppy_response, period_out, update_count);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (state_out !== 3'd1) begin
            miscompares++;
            $display("FAIL reset_hold_wait: state=%0d want 1", state_out);
        end
        for (int k = 0; k < N; k++) pin[k*W +: W] = rand_period();
        transfer("reset_hold_rx", pin, 8'hFF, 1'b0);
    endtask

    task automatic test_timeout();
        period_in      = {N{16'h0777}};
        update_mask    = 8'h0F;
        floppy_command = 1'b1;
        tick(); tick(); tick();
        model_receive({N{16'h0777}}, 8'h0F);
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            vectors++;
            if ({state_out, floppy_response, timeout_err} !== {3'd4, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL timeout_hold[%0d]: state=%0d resp=%0b err=%0b want 4 1 0",
                         i, state_out, floppy_response, timeout_err);
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_err = 1'b1;
            vectors++;
            if ({state_out, floppy_response, timeout_err, busy} !== {3'd5, 1'b0, 1'b1, 1'b1}) begin
                miscompares++;
                $display("FAIL timeout_err[%0d]: state=%0d resp=%0b err=%0b busy=%0b want 5 0 1 1",
                         i, state_out, floppy_response, timeout_err, busy);
            end
        end
        floppy_command = 1'b0;
        tick();
        vectors++;
        if ({state_out, busy, timeout_err, period_out, update_count} !==
            {3'd1, 1'b0, 1'b1, exp_vec(), CW'(exp_cnt)}) begin
            miscompares++;
            $display("FAIL timeout_release: state=%0d busy=%0b err=%0b periods=%h cnt=%0d want 1 0 1 %h %0d",
                     state_out, busy, timeout_err, period_out, update_count, exp_vec(), exp_cnt);
        end
        transfer("after_timeout", {N{16'h0050}}, 8'hF0, 1'b0);
    endtask

    task automatic test_clock_gate();
        clock_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            floppy_command = 1'($urandom);
            reset          = (i % 3 == 1);
            period_in      = {N{W'($urandom)}};
            update_mask    = '1;
            tick();
            vectors++;
            if ({state_out, floppy_response, busy, timeout_err, update_count, period_out} !==
                {3'd1, 1'b0, 1'b0, exp_err, CW'(exp_cnt), exp_vec()}) begin
                miscompares++;
                $display("FAIL clock_gate[%0d]: state=%0d resp=%0b busy=%0b err=%0b cnt=%0d periods=%h",
                         i, state_out, floppy_response, busy, timeout_err, update_count, period_out);
            end
        end
        reset          = 1'b0;
        floppy_command = 1'b0;
        clock_valid    = 1'b1;
        tick();
        vectors++;
        if ({state_out, timeout_err} !== {3'd1, exp_err}) begin
            miscompares++;
            $display("FAIL clock_gate_resume: state/err=%0d/%0b want 1/%0b", state_out, timeout_err, exp_err);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_update();
        test_mask();
        test_clamp();
        test_random();
        test_reset_in_hold();
        test_timeout();
        test_clock_gate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
